// File: rtl/compare_cards_pkg.sv
// Shared constants and face-value mapping for the 6x6 memory card match checker.
// Locations i and i+18 carry the same face value, so they form a pair.
package compare_cards_pkg;

    localparam int NUM_CARDS = 36;
    localparam int NUM_PAIRS = 18;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PLAY = 3'd2;

    typedef enum logic {
        PICK_FIRST  = 1'b0,
        PICK_SECOND = 1'b1
    } pick_e;

    function automatic logic [4:0] card_val(input logic [5:0] idx);
        return 5'(idx % 6'(NUM_PAIRS)) ^ 5'b01111;
    endfunction

endpackage

// File: rtl/card_rom.sv
// Combinational grid-index to face-value lookup.
module card_rom
    import compare_cards_pkg::*;
(
    input  logic [5:0] idx,
    output logic [4:0] val
);

    assign val = card_val(idx);

endmodule

// File: rtl/compare_cards.sv
// Match-checking core: takes two picks per turn, tracks matched cards and pair count,
// and raises GO once every pair has been found.
module compare_cards
    import compare_cards_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        A,
    input  logic [2:0]  inputState,
    input  logic [5:0]  mem6x6,
    output logic        GO,
    output logic [31:0] pairsFound,
    output logic [4:0]  data1,
    output logic [4:0]  data2,
    output logic        cardOneTwo,
    output logic [5:0]  card1Loc,
    output logic [5:0]  card2Loc,
    output logic [5:0]  selectedCard
);

    logic                 a_prev;
    logic                 press;
    logic                 in_range;
    logic                 already_matched;
    logic                 same_as_first;
    logic                 accept;
    logic                 is_match;
    logic [4:0]           pick_val;
    logic [4:0]           card1_val;

    pick_e                pick_q, pick_d;
    logic [NUM_CARDS-1:0] matched, matched_d;
    logic                 go_d;
    logic [31:0]          pairs_d;
    logic [4:0]           data1_d, data2_d;
    logic [5:0]           card1_d, card2_d, sel_d;

    card_rom u_pick_rom  (.idx(mem6x6),   .val(pick_val));
    card_rom u_first_rom (.idx(card1Loc), .val(card1_val));

    // A held high produces a single press on its rising edge.
    assign press           = A & ~a_prev;
    assign in_range        = (mem6x6 < 6'(NUM_CARDS));
    assign already_matched = in_range & matched[mem6x6];
    assign same_as_first   = (pick_q == PICK_SECOND) && (mem6x6 == card1Loc);
    assign accept          = press && (inputState == ST_PLAY) && !GO && in_range
                             && !already_matched && !same_as_first;
    assign is_match        = (card1_val == pick_val);
    assign cardOneTwo      = (pick_q == PICK_SECOND);

    always_comb begin
        // NOTE: every next-state value defaults to hold first, so no path can infer a latch.
        pick_d    = pick_q;
        matched_d = matched;
        go_d      = GO;
        pairs_d   = pairsFound;
        data1_d   = data1;
        data2_d   = data2;
        card1_d   = card1Loc;
        card2_d   = card2Loc;
        sel_d     = selectedCard;

        if (inputState == ST_IDLE) begin
            pick_d    = PICK_FIRST;
            matched_d = '0;
            go_d      = 1'b0;
            pairs_d   = '0;
            data1_d   = '0;
            data2_d   = '0;
            card1_d   = '0;
            card2_d   = '0;
            sel_d     = '0;
        end else if (inputState == ST_PLAY) begin
            if (accept) begin
                sel_d = mem6x6;
                if (pick_q == PICK_FIRST) begin
                    card1_d = mem6x6;
                    data1_d = pick_val;
                    pick_d  = PICK_SECOND;
                end else begin
                    card2_d = mem6x6;
                    data2_d = pick_val;
                    pick_d  = PICK_FIRST;
                    if (is_match) begin
                        matched_d[card1Loc] = 1'b1;
                        matched_d[mem6x6]   = 1'b1;
                        pairs_d             = pairsFound + 32'd1;
                    end
                end
            end
            // GO trails the final pair by one edge and is sticky until the game clears.
            if (pairsFound == 32'(NUM_PAIRS)) begin
                go_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            a_prev       <= 1'b0;
            pick_q       <= PICK_FIRST;
            // NOTE: the matched mask is a flop vector, not a RAM, so it is reset with the rest.
            matched      <= '0;
            GO           <= 1'b0;
            pairsFound   <= '0;
            data1        <= '0;
            data2        <= '0;
            card1Loc     <= '0;
            card2Loc     <= '0;
            selectedCard <= '0;
        end else begin
            a_prev       <= A;
            pick_q       <= pick_d;
            matched      <= matched_d;
            GO           <= go_d;
            pairsFound   <= pairs_d;
            data1        <= data1_d;
            data2        <= data2_d;
            card1Loc     <= card1_d;
            card2Loc     <= card2_d;
            selectedCard <= sel_d;
        end
    end

endmodule

// File: tb/tb_compare_cards.sv
// Self-checking bench for compare_cards: directed vector table, multi-cycle corner
// sequences, and a randomised pick stream checked against a small reference model.
module tb_compare_cards;

    logic        clock = 1'b0;
    logic        reset;
    logic        A;
    logic [2:0]  inputState;
    logic [5:0]  mem6x6;
    logic        GO;
    logic [31:0] pairsFound;
    logic [4:0]  data1, data2;
    logic        cardOneTwo;
    logic [5:0]  card1Loc, card2Loc, selectedCard;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    compare_cards dut (
        .clock       (clock),
        .reset       (reset),
        .A           (A),
        .inputState  (inputState),
        .mem6x6      (mem6x6),
        .GO          (GO),
        .pairsFound  (pairsFound),
        .data1       (data1),
        .data2       (data2),
        .cardOneTwo  (cardOneTwo),
        .card1Loc    (card1Loc),
        .card2Loc    (card2Loc),
        .selectedCard(selectedCard)
    );

    typedef struct {
        logic [5:0] idx;
        logic [2:0] st;
        logic       c12;
        logic [5:0] c1;
        logic [5:0] c2;
        logic [5:0] sel;
        logic [4:0] d1;
        logic [4:0] d2;
        int         pairs;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic c12, input logic [5:0] c1,
                             input logic [5:0] c2, input logic [5:0] sel, input logic [4:0] d1,
                             input logic [4:0] d2, input int pairs, input logic go);
        check({tag, ".cardOneTwo"},   32'(cardOneTwo),   32'(c12));
        check({tag, ".card1Loc"},     32'(card1Loc),     32'(c1));
        check({tag, ".card2Loc"},     32'(card2Loc),     32'(c2));
        check({tag, ".selectedCard"}, 32'(selectedCard), 32'(sel));
        check({tag, ".data1"},        32'(data1),        32'(d1));
        check({tag, ".data2"},        32'(data2),        32'(d2));
        check({tag, ".pairsFound"},   pairsFound,        32'(pairs));
        check({tag, ".GO"},           32'(GO),           32'(go));
    endtask

    // One press: A rises for one clock, then falls; ends on a falling edge after the update.
    task automatic press(input logic [5:0] idx, input logic [2:0] st);
        @(negedge clock);
        inputState = st;
        mem6x6     = idx;
        A          = 1'b1;
        @(negedge clock);
        A = 1'b0;
    endtask

    function automatic logic [4:0] tv(input int i);
        return 5'(i % 18) ^ 5'b01111;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         m_matched[36];
        int         m_pairs;
        bit         m_c12;
        int         m_c1;
        logic [4:0] m_d1, m_d2;
        logic [5:0] idx;
        bit         acc;

        //               idx    st    c12   c1     c2     sel    d1      d2      pairs
        vecs[0]  = '{6'd0,  3'd2, 1'b1, 6'd0,  6'd0,  6'd0,  5'd15, 5'd0,  0};
        vecs[1]  = '{6'd18, 3'd2, 1'b0, 6'd0,  6'd18, 6'd18, 5'd15, 5'd15, 1};
        vecs[2]  = '{6'd5,  3'd2, 1'b1, 6'd5,  6'd18, 6'd5,  5'd10, 5'd15, 1};
        vecs[3]  = '{6'd5,  3'd2, 1'b1, 6'd5,  6'd18, 6'd5,  5'd10, 5'd15, 1};
        vecs[4]  = '{6'd23, 3'd2, 1'b0, 6'd5,  6'd23, 6'd23, 5'd10, 5'd10, 2};
        vecs[5]  = '{6'd0,  3'd2, 1'b0, 6'd5,  6'd23, 6'd23, 5'd10, 5'd10, 2};
        vecs[6]  = '{6'd40, 3'd2, 1'b0, 6'd5,  6'd23, 6'd23, 5'd10, 5'd10, 2};
        vecs[7]  = '{6'd1,  3'd2, 1'b1, 6'd1,  6'd23, 6'd1,  5'd14, 5'd10, 2};
        vecs[8]  = '{6'd2,  3'd2, 1'b0, 6'd1,  6'd2,  6'd2,  5'd14, 5'd13, 2};
        vecs[9]  = '{6'd18, 3'd2, 1'b0, 6'd1,  6'd2,  6'd2,  5'd14, 5'd13, 2};
        vecs[10] = '{6'd35, 3'd2, 1'b1, 6'd35, 6'd2,  6'd35, 5'd30, 5'd13, 2};
        vecs[11] = '{6'd17, 3'd2, 1'b0, 6'd35, 6'd17, 6'd17, 5'd30, 5'd30, 3};
        vecs[12] = '{6'd4,  3'd3, 1'b0, 6'd35, 6'd17, 6'd17, 5'd30, 5'd30, 3};
        vecs[13] = '{6'd36, 3'd2, 1'b0, 6'd35, 6'd17, 6'd17, 5'd30, 5'd30, 3};
        vecs[14] = '{6'd4,  3'd2, 1'b1, 6'd4,  6'd17, 6'd4,  5'd11, 5'd30, 3};
        vecs[15] = '{6'd63, 3'd2, 1'b1, 6'd4,  6'd17, 6'd4,  5'd11, 5'd30, 3};
        vecs[16] = '{6'd22, 3'd1, 1'b1, 6'd4,  6'd17, 6'd4,  5'd11, 5'd30, 3};

        reset      = 1'b1;
        A          = 1'b0;
        inputState = 3'd2;
        mem6x6     = 6'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_all("reset", 1'b0, 6'd0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].idx, vecs[i].st);
            check_all($sformatf("vec%0d", i), vecs[i].c12, vecs[i].c1, vecs[i].c2, vecs[i].sel,
                      vecs[i].d1, vecs[i].d2, vecs[i].pairs, 1'b0);
        end

        press(6'd22, 3'd2);
        check_all("match_after_hold_state", 1'b0, 6'd4, 6'd22, 6'd22, 5'd11, 5'd11, 4, 1'b0);

        // A held for five cycles while the cursor moves: only the first edge picks.
        @(negedge clock);
        inputState = 3'd2;
        mem6x6     = 6'd6;
        A          = 1'b1;
        @(negedge clock);
        mem6x6 = 6'd7;
        repeat (4) @(negedge clock);
        A = 1'b0;
        check_all("held_A", 1'b1, 6'd6, 6'd22, 6'd6, 5'd9, 5'd11, 4, 1'b0);
        press(6'd24, 3'd2);
        check_all("held_A_pair", 1'b0, 6'd6, 6'd24, 6'd24, 5'd9, 5'd9, 5, 1'b0);

        @(negedge clock);
        inputState = 3'd0;
        @(negedge clock);
        check_all("idle_clear", 1'b0, 6'd0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 1'b0);

        // Full game: card 0 is playable again only if IDLE cleared the mask.
        for (int i = 0; i < 18; i++) begin
            press(6'(i), 3'd2);
            press(6'(i + 18), 3'd2);
            check($sformatf("full_game_pairs%0d", i), pairsFound, 32'(i + 1));
        end
        check("go_lag", 32'(GO), 32'd0);
        @(negedge clock);
        check_all("go_set", 1'b0, 6'd17, 6'd35, 6'd35, 5'd30, 5'd30, 18, 1'b1);
        press(6'd3, 3'd2);
        check_all("after_go", 1'b0, 6'd17, 6'd35, 6'd35, 5'd30, 5'd30, 18, 1'b1);

        @(negedge clock);
        inputState = 3'd0;
        @(negedge clock);
        check_all("idle_after_go", 1'b0, 6'd0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            press(6'(i), 3'd2);
            press(6'(i + 18), 3'd2);
        end
        press(6'd9, 3'd2);
        check("midgame_pairs", pairsFound, 32'd3);
        check("midgame_c12", 32'(cardOneTwo), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all("midgame_reset", 1'b0, 6'd0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 1'b0);

        m_pairs = 0;
        m_c12   = 1'b0;
        m_c1    = 0;
        m_d1    = '0;
        m_d2    = '0;
        foreach (m_matched[k]) m_matched[k] = 1'b0;

        for (int n = 0; n < 1600; n++) begin
            if (m_c12 && ($urandom_range(0, 1) == 1))
                idx = 6'((m_c1 < 18) ? m_c1 + 18 : m_c1 - 18);
            else
                idx = 6'($urandom_range(0, 40));
            press(idx, 3'd2);

            acc = (idx < 6'd36) && !m_matched[idx] && !(m_c12 && (int'(idx) == m_c1));
            if (acc) begin
                if (!m_c12) begin
                    m_c1  = int'(idx);
                    m_d1  = tv(int'(idx));
                    m_c12 = 1'b1;
                end else begin
                    m_d2 = tv(int'(idx));
                    if (tv(m_c1) == tv(int'(idx))) begin
                        m_matched[m_c1] = 1'b1;
                        m_matched[idx]  = 1'b1;
                        m_pairs++;
                    end
                    m_c12 = 1'b0;
                end
            end
            check("rnd_pairs",    pairsFound,       32'(m_pairs));
            check("rnd_c12",      32'(cardOneTwo),  32'(m_c12));
            check("rnd_card1Loc", 32'(card1Loc),    32'(m_c1));
            check("rnd_data1",    32'(data1),       32'(m_d1));
            check("rnd_data2",    32'(data2),       32'(m_d2));
            check("rnd_sat",      32'(pairsFound <= 32'd18), 32'd1);
            @(negedge clock);
            check("rnd_go", 32'(GO), 32'(m_pairs == 18));

            if (m_pairs == 18) begin
                inputState = 3'd0;
                @(negedge clock);
                inputState = 3'd2;
                m_pairs = 0;
                m_c12   = 1'b0;
                m_c1    = 0;
                m_d1    = '0;
                m_d2    = '0;
                foreach (m_matched[k]) m_matched[k] = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
